// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // A request faults when it is not word aligned or falls past the last word.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM with per-byte write enables and a combinational read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the core: one request at a time, WAIT_CYCLES wait
// states, registered response, and a sticky flag for a full-word store to DONE_ADDR.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] DONE_ADDR   = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        done,
  output logic [31:0] done_data
);

  localparam int AW = $clog2(DEPTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;
  logic             done_q;
  logic [31:0]      done_data_q;

  logic             accept_d;
  logic             err_d;
  logic             done_hit_d;
  logic [3:0]       we_d;
  logic [31:0]      ram_rdata;
  logic [31:0]      rdata_d;

  assign accept_d   = (state_q == IDLE) && req_valid;
  assign err_d      = addr_err(req_addr, 32'(DEPTH));
  // Stores commit on the acceptance edge, so a later reset cannot undo them.
  assign we_d       = (accept_d && req_write && !err_d) ? req_wstrb : 4'h0;
  assign done_hit_d = req_write && !err_d && (req_wstrb == 4'hF) && (req_addr == DONE_ADDR);
  assign rdata_d    = (req_write || err_d) ? 32'h0 : ram_rdata;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (we_d),
    .addr_i  (req_addr[AW+1:2]),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      done_q      <= 1'b0;
      done_data_q <= 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_err_q   <= err_d;
            rsp_rdata_q <= rdata_d;
            if (done_hit_d && !done_q) begin
              done_q      <= 1'b1;
              done_data_q <= req_wdata;
            end
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              cnt_q   <= CNT_W'(WAIT_CYCLES);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign done      = done_q;
  assign done_data = done_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a zero-wait and a three-wait instance share
// the request bus; expected responses are queued at issue and checked on rsp_valid.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v3;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;

  logic        rdy0, rv0, err0, dn0;
  logic [31:0] rd0, dd0;
  logic        rdy3, rv3, err3, dn3;
  logic [31:0] rd3, dd3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        e;
    logic [31:0] d;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .DONE_ADDR(32'd100)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0), .done(dn0), .done_data(dd0)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(3), .DONE_ADDR(32'd100)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3), .done(dn3), .done_data(dd3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int s);
    return (s == 0) ? rdy0 : rdy3;
  endfunction
  function automatic logic rv_of(input int s);
    return (s == 0) ? rv0 : rv3;
  endfunction
  function automatic logic err_of(input int s);
    return (s == 0) ? err0 : err3;
  endfunction
  function automatic logic [31:0] rd_of(input int s);
    return (s == 0) ? rd0 : rd3;
  endfunction

  task automatic xact(input string tag, input int s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] st,
                      input logic [31:0] exp_d, input logic exp_e);
    int   lat;
    bit   got;
    exp_t e;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = st;
    if (s == 0) v0 = 1'b1;
    else        v3 = 1'b1;
    sb_q.push_back({exp_e, exp_d});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy_of(s);
    end
    chk({tag, "/accept"}, 32'(got), 32'd1);
    if (!got) begin
      v0 = 1'b0;
      v3 = 1'b0;
      e  = sb_q.pop_front();
      return;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v3 = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = rv_of(s);
    end
    chk({tag, "/latency"}, 32'(lat), (s == 0) ? 32'd1 : 32'd4);
    e = sb_q.pop_front();
    if (got) begin
      chk({tag, "/rdata"}, rd_of(s), e.d);
      chk({tag, "/err"}, 32'(err_of(s)), 32'(e.e));
      @(negedge clk);
      chk({tag, "/pulse"}, 32'(rv_of(s)), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   got;
    exp_t e;
    reset = 1'b0; v0 = 1'b0; v3 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (2) @(negedge clk);
    chk("rst0/ready", 32'(rdy0), 32'd1);
    chk("rst0/rv",    32'(rv0),  32'd0);
    chk("rst0/rdata", rd0,       32'd0);
    chk("rst0/err",   32'(err0), 32'd0);
    chk("rst0/done",  32'(dn0),  32'd0);
    chk("rst0/ddata", dd0,       32'd0);
    chk("rst3/ready", 32'(rdy3), 32'd1);
    chk("rst3/rv",    32'(rv3),  32'd0);
    reset = 1'b1;
    @(negedge clk);

    xact("st60",  0, 1'b1, 32'h60, 32'h19,       4'hF,    32'h0,        1'b0);
    xact("ld60",  0, 1'b0, 32'h60, 32'h0,        4'h0,    32'h19,       1'b0);
    xact("st10",  0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF,    32'h0,        1'b0);
    xact("st10b", 0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0,        1'b0);
    xact("ld10",  0, 1'b0, 32'h10, 32'h0,        4'h0,    32'hAA22CC44, 1'b0);
    xact("st00",  0, 1'b1, 32'h0,  32'h12345678, 4'hF,    32'h0,        1'b0);
    xact("ld62",  0, 1'b0, 32'h62, 32'h0,        4'h0,    32'h0,        1'b1);
    xact("st400", 0, 1'b1, 32'h400, 32'hDEADBEEF, 4'hF,   32'h0,        1'b1);
    xact("ld00",  0, 1'b0, 32'h0,  32'h0,        4'h0,    32'h12345678, 1'b0);
    xact("st60z", 0, 1'b1, 32'h60, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0);
    xact("ld60z", 0, 1'b0, 32'h60, 32'h0,        4'h0,    32'h19,       1'b0);

    chk("done0/pre", 32'(dn0), 32'd0);
    xact("stdone", 0, 1'b1, 32'd100, 32'd25, 4'hF, 32'h0, 1'b0);
    chk("done0/set",  32'(dn0), 32'd1);
    chk("done0/data", dd0,      32'd25);
    xact("stdone7", 0, 1'b1, 32'd100, 32'd7, 4'hF, 32'h0, 1'b0);
    chk("done0/sticky", dd0, 32'd25);
    xact("ld100", 0, 1'b0, 32'd100, 32'h0, 4'h0, 32'd7, 1'b0);

    xact("w3/st20",   1, 1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xact("w3/stdone", 1, 1'b1, 32'd100, 32'h55,       4'hF, 32'h0, 1'b0);
    chk("w3/done", 32'(dn3), 32'd1);

    // Back-to-back loads with valid held through the busy window.
    req_write = 1'b0; req_addr = 32'h20; req_wdata = '0; req_wstrb = '0;
    v3 = 1'b1;
    sb_q.push_back({1'b0, 32'hCAFEF00D});
    sb_q.push_back({1'b0, 32'hCAFEF00D});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy3;
    end
    chk("win/accept", 32'(got), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 4) chk("win/ready_low", 32'(rdy3), 32'd0);
      if (k == 5) chk("win/ready_high", 32'(rdy3), 32'd1);
      chk("win/rv", 32'(rv3), (k == 4 || k == 9) ? 32'd1 : 32'd0);
      if ((k == 4 || k == 9) && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("win/rdata", rd3, e.d);
      end
      if (k == 5) begin
        @(posedge clk);
        #1;
        v3 = 1'b0;
      end
    end
    @(negedge clk);

    // Reset dropped while the three-wait instance is counting.
    req_write = 1'b0; req_addr = 32'h20;
    v3 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy3;
    end
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rstw/ready", 32'(rdy3), 32'd1);
    chk("rstw/rv",    32'(rv3),  32'd0);
    chk("rstw/rdata", rd3,       32'd0);
    chk("rstw/err",   32'(err3), 32'd0);
    chk("rstw/done",  32'(dn3),  32'd0);
    chk("rstw/ddata", dd3,       32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv3) got = 1'b1;
    end
    chk("rstw/no_rsp", 32'(got), 32'd0);
    xact("rstw/ld20", 1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

    xact("st100h", 0, 1'b1, 32'd100, 32'h4444, 4'b0011, 32'h0, 1'b0);
    chk("partial/done", 32'(dn0), 32'd0);
    xact("ld100h", 0, 1'b0, 32'd100, 32'h0, 4'h0, 32'h00004444, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target end of the core's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte-masked writes or word reads against an internal word-addressed RAM. After a programmable number of wait states it returns a registered response. It also records the first full-word store to a configurable "done" address, so benches and SoC glue can detect program completion without snooping the bus.

## Interface
- DEPTH, 256: RAM size in 32-bit words; power of two.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response (0..15).
- DONE_ADDR, 100: byte address whose full-word store sets `done`.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  byte enables for a store; bit i covers bits 8i+7:8i
- rsp_valid  out  1  response present, single-cycle pulse
- rsp_rdata  out  32  load data; 0 on stores and on errors
- rsp_err  out  1  request was misaligned or out of range
- done  out  1  sticky; set by a full-word store to DONE_ADDR
- done_data  out  32  data of the store that set `done`

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, the request is accepted and latched.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter reaches 1, go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, `req_ready`=0, then return to IDLE.
- No response backpressure. The initiator must sample `rsp_valid` in that cycle.
- Error: `req_addr[1:0]`≠0, or `req_addr[31:2]`≥DEPTH.
  - The RAM is untouched.
  - `rsp_err`=1 and `rsp_rdata`=0.
  - `done` is unaffected.
- Store, no error:
  - RAM byte lanes with `req_wstrb[i]`=1 are written on the acceptance edge; other lanes are kept.
  - `req_wstrb`=0 is legal: no write, normal response.
- Load, no error: `rsp_rdata` holds the word as RAM contains it at the acceptance edge. It is captured then and held until RESP.
- Done:
  - Set on acceptance of a non-error store with `req_addr`==DONE_ADDR and `req_wstrb`=4'hF.
  - `done_data` captures `req_wdata` at the same time.
  - The store also updates the RAM.
  - Later stores to DONE_ADDR do not change `done_data`.
- RAM contents are not reset. Load from an unwritten location returns X in simulation; the bench must not rely on it.

## Timing
- Reset values (asynchronous):
  - state=IDLE; `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `done`=0, `done_data`=0; wait counter=0.
- Latency: request accepted at edge N gives `rsp_valid` high in cycle N+1+WAIT_CYCLES.
- Throughput: one request per 2+WAIT_CYCLES cycles.
- `rsp_rdata` and `rsp_err` are registered. They are valid only while `rsp_valid`=1 and hold their value otherwise.
- `done` rises in the cycle after the acceptance edge, together with RESP when WAIT_CYCLES=0.
- Reset asserted mid-transaction:
  - The state machine returns to IDLE.
  - Any pending response is dropped.
  - A store already committed at acceptance stays in RAM.
- Request inputs are ignored while `req_ready`=0.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - wait-counter width constant (4);
  - helper function for the error check (alignment and range versus DEPTH).
- Sub-module `dmem_array`:
  - DEPTH×32 RAM with a 4-bit byte-lane write enable and an asynchronous read port;
  - no reset.
- `dmem_responder` holds the FSM, counter, response registers and done logic.

## Test plan
- WAIT_CYCLES=0: store 0x0000_0019 to 0x60 with wstrb=F, then load 0x60. Each `rsp_valid` comes 1 cycle after acceptance. Load returns 0x19 with `rsp_err`=0.
- Byte lanes: store 0xAABBCCDD to 0x10 with wstrb=F, then store 0x11223344 with wstrb=0101. Load 0x10 returns 0xAA22CC44.
- WAIT_CYCLES=3: accept a load at edge N. `rsp_valid` is high only in cycle N+4. `req_ready` is low in cycles N+1..N+4. A second `req_valid` held during that window is not accepted until cycle N+5.
- Errors: load 0x62 gives `rsp_err`=1 and `rsp_rdata`=0. Store to 0x400 with DEPTH=256 gives `rsp_err`=1, and a later load of 0x0 is unchanged.
- Done:
  - Store 25 to address 100 with wstrb=F sets `done`=1 and `done_data`=25.
  - A later store of 7 to address 100 leaves `done_data`=25 while the RAM reads 7.
  - Store to 100 with wstrb=0011 on a fresh reset does not set `done`.
- Reset: drop `reset` low during WAIT. Outputs go to reset values asynchronously and no `rsp_valid` is produced. After release, the next request completes normally.
